bsg_link_sdr_rx_endpoint: RTL and testbench



---
 rtl/bsg_link_sdr_rx_pkg.sv | 36 +++
 rtl/bsg_link_sdr_rx_token_gen.sv | 86 ++++++++
 rtl/bsg_link_sdr_rx_endpoint.sv | 146 ++++++++++++++
 tb/tb_bsg_link_sdr_rx_endpoint.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_link_sdr_rx_pkg.sv
// bsg_link_sdr_rx_pkg
// Shared sizing helpers and the token FSM state type for the SDR link
// receive endpoint. The sizing functions take the two lg parameters, so every
// module that imports this package derives the same widths from them.
package bsg_link_sdr_rx_pkg;

  // Default configuration (width 16, 8-entry FIFO, one token per 2 words).
  localparam int unsigned LG_FIFO_DEPTH_DFLT = 3;
  localparam int unsigned LG_DECIMATION_DFLT = 1;

  // Number of FIFO entries.
  function automatic int unsigned fifo_depth(input int unsigned lg_depth);
    return 32'(1) << lg_depth;
  endfunction

  // FIFO pointer width: address bits plus one wrap bit for full/empty.
  function automatic int unsigned ptr_width(input int unsigned lg_depth);
    return lg_depth + 1;
  endfunction

  // Pending-token counter width; holds up to depth / 2^decimation.
  function automatic int unsigned pend_width(input int unsigned lg_depth,
                                             input int unsigned lg_dec);
    return lg_depth - lg_dec + 1;
  endfunction

  localparam int unsigned FIFO_DEPTH_DFLT = fifo_depth(LG_FIFO_DEPTH_DFLT);
  localparam int unsigned PTR_W_DFLT      = ptr_width(LG_FIFO_DEPTH_DFLT);
  localparam int unsigned PEND_W_DFLT     = pend_width(LG_FIFO_DEPTH_DFLT, LG_DECIMATION_DFLT);

  typedef enum logic {
    e_tok_low  = 1'b0,
    e_tok_high = 1'b1
  } tok_state_e;

endpackage

// File: rtl/bsg_link_sdr_rx_token_gen.sv
// bsg_link_sdr_rx_token_gen
// Converts dequeue events into token pulses for the link sender: one pulse per
// 2^lg_credit_to_token_decimation_p dequeues. Pulses are one cycle high with
// at least one low cycle between them; a backlog of owed tokens drains at one
// pulse every two cycles.
// Ports:
//   core_clk_i      clock
//   core_reset_n_i  asynchronous active-low reset
//   yumi_i          one accepted dequeue this cycle
//   link_token_o    registered token pulse back to the sender
module bsg_link_sdr_rx_token_gen
  import bsg_link_sdr_rx_pkg::*;
#(
  parameter int unsigned lg_fifo_depth_p                 = LG_FIFO_DEPTH_DFLT,
  parameter int unsigned lg_credit_to_token_decimation_p = LG_DECIMATION_DFLT
) (
  input  logic core_clk_i,
  input  logic core_reset_n_i,
  input  logic yumi_i,
  output logic link_token_o
);

  localparam int unsigned PEND_W = pend_width(lg_fifo_depth_p, lg_credit_to_token_decimation_p);
  localparam int unsigned CRED_W = lg_credit_to_token_decimation_p;

  logic credit_wrap_c;

  // Credit counter: flags the dequeue that completes a decimation group.
  if (CRED_W == 0) begin : g_no_dec
    assign credit_wrap_c = yumi_i;
  end else begin : g_dec
    logic [CRED_W-1:0] credit_q, credit_d;

    always_comb begin
      credit_d = credit_q;
      if (yumi_i) credit_d = credit_q + CRED_W'(1);
    end

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i) credit_q <= '0;
      else                 credit_q <= credit_d;
    end

    assign credit_wrap_c = yumi_i && (credit_q == '1);
  end

  tok_state_e        state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              token_q, token_d;
  logic              fire_c;

  // Next state: a group completing this cycle counts as owed immediately, so
  // it can be emitted without first passing through the pending counter.
  always_comb begin
    state_d = state_q;
    token_d = 1'b0;
    fire_c  = 1'b0;
    case (state_q)
      e_tok_low: begin
        if ((pend_q != '0) || credit_wrap_c) begin
          state_d = e_tok_high;
          token_d = 1'b1;
          fire_c  = 1'b1;
        end
      end
      e_tok_high: state_d = e_tok_low;
      default:    state_d = e_tok_low;
    endcase
    pend_d = pend_q + PEND_W'(credit_wrap_c) - PEND_W'(fire_c);
  end

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      state_q <= e_tok_low;
      pend_q  <= '0;
      token_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      token_q <= token_d;
    end
  end

  assign link_token_o = token_q;

endmodule

// File: rtl/bsg_link_sdr_rx_endpoint.sv
// bsg_link_sdr_rx_endpoint
// Single-clock receive end of the credit/token SDR link. Link words are
// registered, buffered in a 2^lg_fifo_depth_p-entry FIFO and offered to the
// core with valid/yumi; dequeues are returned to the sender as token pulses.
// Optional feature macro: BSG_LINK_SDR_RX_OVERFLOW_DET_EN
//   defined   - a word arriving while full (and no same-cycle dequeue) is
//               dropped and sets the sticky overflow_o flag
//   undefined - overflow_o is tied low and enqueue follows link valid only
// Ports:
//   core_clk_i      sole clock, link inputs sampled on it
//   core_reset_n_i  asynchronous active-low reset
//   link_v_i        incoming word valid
//   link_data_i     incoming word
//   link_token_o    token pulse back to sender
//   core_v_o        FIFO head valid
//   core_data_o     FIFO head data (don't-care when core_v_o=0)
//   core_yumi_i     core consumes head
//   overflow_o      sticky protocol-violation flag
module bsg_link_sdr_rx_endpoint
  import bsg_link_sdr_rx_pkg::*;
#(
  parameter int unsigned width_p                         = 16,
  parameter int unsigned lg_fifo_depth_p                 = LG_FIFO_DEPTH_DFLT,
  parameter int unsigned lg_credit_to_token_decimation_p = LG_DECIMATION_DFLT
) (
  input  logic               core_clk_i,
  input  logic               core_reset_n_i,
  input  logic               link_v_i,
  input  logic [width_p-1:0] link_data_i,
  output logic               link_token_o,
  output logic               core_v_o,
  output logic [width_p-1:0] core_data_o,
  input  logic               core_yumi_i,
  output logic               overflow_o
);

  localparam int unsigned DEPTH  = fifo_depth(lg_fifo_depth_p);
  localparam int unsigned PTR_W  = ptr_width(lg_fifo_depth_p);
  localparam int unsigned ADDR_W = lg_fifo_depth_p;

  if (lg_credit_to_token_decimation_p > lg_fifo_depth_p) begin : g_bad_dec
    $error("lg_credit_to_token_decimation_p must not exceed lg_fifo_depth_p");
  end
  if (lg_fifo_depth_p < 1) begin : g_bad_depth
    $error("lg_fifo_depth_p must be at least 1");
  end

  // Link input registers, no handshake.
  logic               link_v_q, link_v_d;
  logic [width_p-1:0] link_data_q, link_data_d;

  always_comb begin
    link_v_d    = link_v_i;
    link_data_d = link_data_i;
  end

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      link_v_q    <= 1'b0;
      link_data_q <= '0;
    end else begin
      link_v_q    <= link_v_d;
      link_data_q <= link_data_d;
    end
  end

  // FIFO control; pointers carry an extra wrap bit to tell full from empty.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             core_v_q, core_v_d;
  logic             enq_c, deq_c;

  // A yumi without a valid head is ignored.
  assign deq_c = core_yumi_i && core_v_q;

`ifdef BSG_LINK_SDR_RX_OVERFLOW_DET_EN
  logic full_c, drop_c;
  logic overflow_q, overflow_d;

  // Full still accepts a word when the head leaves in the same cycle.
  always_comb begin
    full_c     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1])
              && (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    enq_c      = link_v_q && (!full_c || deq_c);
    drop_c     = link_v_q && full_c && !deq_c;
    overflow_d = overflow_q || drop_c;
  end

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) overflow_q <= 1'b0;
    else                 overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;

`ifndef SYNTHESIS
  // Report only the first drop; the flag itself stays sticky.
  always_ff @(posedge core_clk_i) begin
    if (core_reset_n_i && drop_c && !overflow_q)
      $warning("bsg_link_sdr_rx_endpoint overflow error: word dropped at %0t", $time);
  end
`endif
`else
  assign enq_c      = link_v_q;
  assign overflow_o = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(enq_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(deq_c);
    core_v_d = (wr_ptr_d != rd_ptr_d);
  end

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      core_v_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      core_v_q <= core_v_d;
    end
  end

  // FIFO storage: data-only, no reset needed.
  logic [width_p-1:0] mem_q [DEPTH];

  always_ff @(posedge core_clk_i) begin
    if (enq_c) mem_q[wr_ptr_q[ADDR_W-1:0]] <= link_data_q;
  end

  assign core_v_o    = core_v_q;
  assign core_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];

  bsg_link_sdr_rx_token_gen #(
    .lg_fifo_depth_p                 (lg_fifo_depth_p),
    .lg_credit_to_token_decimation_p (lg_credit_to_token_decimation_p)
  ) u_token_gen (
    .core_clk_i     (core_clk_i),
    .core_reset_n_i (core_reset_n_i),
    .yumi_i         (deq_c),
    .link_token_o   (link_token_o)
  );

endmodule

// File: tb/tb_bsg_link_sdr_rx_endpoint.sv
// Directed bench for bsg_link_sdr_rx_endpoint: one instance with decimation 1
// and one with decimation 0, sharing clock and reset.
module tb_bsg_link_sdr_rx_endpoint;

  localparam int unsigned W = 16;

`ifdef BSG_LINK_SDR_RX_OVERFLOW_DET_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         link_v, yumi, tok, core_v, ovf;
  logic [W-1:0] link_data, core_data;
  logic         l0_v, y0, tok0, v0, ovf0;
  logic [W-1:0] l0_data, d0;

  always #5 clk = ~clk;

  bsg_link_sdr_rx_endpoint #(
    .width_p(W), .lg_fifo_depth_p(3), .lg_credit_to_token_decimation_p(1)
  ) dut (
    .core_clk_i(clk), .core_reset_n_i(rst_n),
    .link_v_i(link_v), .link_data_i(link_data), .link_token_o(tok),
    .core_v_o(core_v), .core_data_o(core_data), .core_yumi_i(yumi),
    .overflow_o(ovf)
  );

  bsg_link_sdr_rx_endpoint #(
    .width_p(W), .lg_fifo_depth_p(3), .lg_credit_to_token_decimation_p(0)
  ) dut0 (
    .core_clk_i(clk), .core_reset_n_i(rst_n),
    .link_v_i(l0_v), .link_data_i(l0_data), .link_token_o(tok0),
    .core_v_o(v0), .core_data_o(d0), .core_yumi_i(y0),
    .overflow_o(ovf0)
  );

  int vectors = 0;
  int miscompares = 0;

  // Token monitor for the main instance: high cycles and back-to-back highs.
  int   tok_cnt  = 0;
  int   tok_b2b  = 0;
  logic tok_prev = 1'b0;

  always @(negedge clk) begin
    if (tok) tok_cnt <= tok_cnt + 1;
    if (tok && tok_prev) tok_b2b <= tok_b2b + 1;
    tok_prev <= tok;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      link_v    = 1'b1;
      link_data = base + W'(i);
      step();
    end
    link_v = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] w;
    int tb, bb;

    rst_n = 1'b0; link_v = 1'b0; link_data = '0; yumi = 1'b0;
    l0_v = 1'b0; l0_data = '0; y0 = 1'b0;
    #1;
    chk_eq("rst_core_v", 32'(core_v), 32'(0));
    chk_eq("rst_token", 32'(tok), 32'(0));
    chk_eq("rst_ovf", 32'(ovf), 32'(0));
    chk_eq("rst_core_v0", 32'(v0), 32'(0));
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single word: two-cycle latency, first yumi gives no token.
    link_v = 1'b1; link_data = 16'hA5A5;
    step();
    link_v = 1'b0;
    chk_eq("t1_lat1_v", 32'(core_v), 32'(0));
    step();
    chk_eq("t1_lat2_v", 32'(core_v), 32'(1));
    chk_eq("t1_data", 32'(core_data), 32'h0000A5A5);
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    chk_eq("t1_empty", 32'(core_v), 32'(0));
    tb = tok_cnt;
    step(4);
    chk_eq("t1_no_tok", 32'(tok_cnt - tb), 32'(0));
    // Second word completes the credit group: one single-cycle pulse.
    send(16'h5A5A, 1);
    step();
    chk_eq("t1_data2", 32'(core_data), 32'h00005A5A);
    tb = tok_cnt;
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    chk_eq("t1_tok_hi", 32'(tok), 32'(1));
    step();
    chk_eq("t1_tok_lo", 32'(tok), 32'(0));
    step(3);
    chk_eq("t1_tok_cnt", 32'(tok_cnt - tb), 32'(1));

    // Burst of 8 with no yumi, then drain 8 in order with 4 tokens.
    tb = tok_cnt; bb = tok_b2b;
    send(16'h1000, 8);
    step();
    chk_eq("t2_full_v", 32'(core_v), 32'(1));
    chk_eq("t2_head", 32'(core_data), 32'h00001000);
    chk_eq("t2_ovf", 32'(ovf), 32'(0));
    step(2);
    chk_eq("t2_no_tok", 32'(tok_cnt - tb), 32'(0));
    yumi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_eq("t2_drain", 32'(core_data), 32'(16'h1000 + 16'(i)));
      step();
    end
    yumi = 1'b0;
    chk_eq("t2_empty", 32'(core_v), 32'(0));
    step(3);
    chk_eq("t2_tok_cnt", 32'(tok_cnt - tb), 32'(4));
    chk_eq("t2_tok_gap", 32'(tok_b2b - bb), 32'(0));

    // Ninth word while full.
    send(16'h2000, 9);
    step();
    chk_eq("t3_ovf", 32'(ovf), 32'(OVF_EXP));
    step(3);
    chk_eq("t3_ovf_sticky", 32'(ovf), 32'(OVF_EXP));
`ifdef BSG_LINK_SDR_RX_OVERFLOW_DET_EN
    yumi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_eq("t3_kept", 32'(core_data), 32'(16'h2000 + 16'(i)));
      step();
    end
    yumi = 1'b0;
    chk_eq("t3_empty", 32'(core_v), 32'(0));
`endif
    do_reset();
    chk_eq("t3_rst_ovf", 32'(ovf), 32'(0));
    chk_eq("t3_rst_v", 32'(core_v), 32'(0));

    // Full FIFO with enqueue and dequeue together for 20 cycles.
    send(16'h3000, 8);
    step();
    for (int i = 0; i < 8; i++) q.push_back(16'h3000 + 16'(i));
    link_v = 1'b1; link_data = 16'h3100;
    step();
    tb = tok_cnt; bb = tok_b2b;
    for (int j = 1; j <= 20; j++) begin
      if (j < 20) begin
        link_v = 1'b1; link_data = 16'h3100 + 16'(j);
      end else begin
        link_v = 1'b0;
      end
      yumi = 1'b1;
      w = q.pop_front();
      chk_eq("t4_stream", 32'(core_data), 32'(w));
      q.push_back(16'h3100 + 16'(j - 1));
      step();
    end
    yumi = 1'b0;
    chk_eq("t4_occ_v", 32'(core_v), 32'(1));
    chk_eq("t4_ovf", 32'(ovf), 32'(0));
    step(2);
    chk_eq("t4_tok_cnt", 32'(tok_cnt - tb), 32'(10));
    chk_eq("t4_tok_gap", 32'(tok_b2b - bb), 32'(0));
    yumi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = q.pop_front();
      chk_eq("t4_drain", 32'(core_data), 32'(w));
      step();
    end
    yumi = 1'b0;
    chk_eq("t4_empty", 32'(core_v), 32'(0));

    // Decimation 0: yumi on 4 consecutive cycles, pulses at +1,+3,+5,+7.
    for (int i = 0; i < 4; i++) begin
      l0_v = 1'b1; l0_data = 16'h0C00 + 16'(i);
      step();
    end
    l0_v = 1'b0;
    step();
    chk_eq("t5_v0", 32'(v0), 32'(1));
    chk_eq("t5_d0", 32'(d0), 32'h00000C00);
    chk_eq("t5_tok_idle", 32'(tok0), 32'(0));
    y0 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 4) y0 = 1'b0;
      chk_eq("t5_tok_seq", 32'(tok0), 32'((k % 2 == 1) && (k <= 7)));
    end
    chk_eq("t5_empty0", 32'(v0), 32'(0));
    chk_eq("t5_ovf0", 32'(ovf0), 32'(0));

    // Reset mid-operation: 5 buffered words and a token in flight.
    send(16'h4000, 7);
    step();
    yumi = 1'b1;
    step(2);
    yumi = 1'b0;
    chk_eq("t6_pre_tok", 32'(tok), 32'(1));
    chk_eq("t6_pre_v", 32'(core_v), 32'(1));
    chk_eq("t6_pre_head", 32'(core_data), 32'h00004002);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("t6_async_v", 32'(core_v), 32'(0));
    chk_eq("t6_async_tok", 32'(tok), 32'(0));
    chk_eq("t6_async_ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    tb = tok_cnt;
    step(8);
    chk_eq("t6_no_stale_tok", 32'(tok_cnt - tb), 32'(0));
    chk_eq("t6_empty", 32'(core_v), 32'(0));
    send(16'h4444, 1);
    step();
    chk_eq("t6_fresh_v", 32'(core_v), 32'(1));
    chk_eq("t6_fresh_data", 32'(core_data), 32'h00004444);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
